vga_dac_palette: RTL

256-entry × 18-bit VGA DAC palette: the writer and storage behind the 18-bit `vga_dac_rd` value that the pixel colour lookup consumes in 256-colour mode. The CPU programs and reads back entries through the standard DAC ports 0x3C6–0x3C9, using an index register and a three-phase R/G/B sequence with auto-increment. The pixel pipeline presents an 8-bit colour index and receives the registered 18-bit colour one cycle later.

---
 rtl/vga_dac_palette.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/vga_dac_palette.sv
// vga_dac_palette
// 256 x 18-bit VGA DAC palette. The CPU side reaches the DAC ports 0x3C6-0x3C9
// through a small IDLE/BUSY/ACK bus FSM. The pixel side looks up
// ram[pix_idx & pel_mask] into a register every cycle, independent of the CPU.
module vga_dac_palette (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cs,
  input  logic        data_m_addr,
  input  logic [15:0] data_m_data_in,
  output logic [15:0] data_m_data_out,
  input  logic [1:0]  data_m_bytesel,
  input  logic        data_m_wr_en,
  input  logic        data_m_access,
  output logic        data_m_ack,
  input  logic [7:0]  pix_idx,
  output logic [17:0] vga_dac_rd
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_ACK} state_t;
  typedef enum logic [1:0] {PH_R, PH_G, PH_B}      phase_t;

  // Bus FSM and latched request
  state_t      r_state;
  logic        r_skip;        // first IDLE cycle after ACK: ignore requests
  logic        r_req_addr;
  logic        r_req_wr;
  logic [1:0]  r_req_bs;
  logic [15:0] r_req_data;
  logic        r_ack;
  logic [15:0] r_data_out;

  // DAC programming state
  logic [7:0]  r_wr_idx;
  logic [7:0]  r_rd_idx;
  phase_t      r_wr_phase;
  phase_t      r_rd_phase;
  logic [5:0]  r_stage_r;
  logic [5:0]  r_stage_g;
  logic [7:0]  r_pel_mask;
  logic        r_rd_mode;

  // Palette storage and pixel output register
  logic [17:0] ram [256];
  logic [17:0] r_pix;

  // Next-state values produced by the BUSY cycle
  logic [7:0]  w_wr_idx;
  logic [7:0]  w_rd_idx;
  phase_t      w_wr_phase;
  phase_t      w_rd_phase;
  logic [5:0]  w_stage_r;
  logic [5:0]  w_stage_g;
  logic [7:0]  w_pel_mask;
  logic        w_rd_mode;
  logic [15:0] w_rd_data;
  logic        w_ram_we;
  logic [7:0]  w_ram_waddr;
  logic [17:0] w_ram_wdata;
  logic [17:0] w_rd_entry;
  logic [7:0]  w_pix_addr;

  assign w_rd_entry = ram[r_rd_idx];
  assign w_pix_addr = pix_idx & r_pel_mask;

  // Decode the latched request: even lane first, then odd lane, so a dual-lane
  // 0x3C8/0x3C9 write sets the index and then stores R at that index.
  // NOTE: every output gets a default before any branch, so no latch is inferred.
  always_comb begin
    w_wr_idx    = r_wr_idx;
    w_rd_idx    = r_rd_idx;
    w_wr_phase  = r_wr_phase;
    w_rd_phase  = r_rd_phase;
    w_stage_r   = r_stage_r;
    w_stage_g   = r_stage_g;
    w_pel_mask  = r_pel_mask;
    w_rd_mode   = r_rd_mode;
    w_rd_data   = 16'h0000;
    w_ram_we    = 1'b0;
    w_ram_waddr = r_wr_idx;
    w_ram_wdata = 18'h0;

    if (r_state == S_BUSY) begin
      if (!r_req_addr) begin
        // 0x3C6 (even) / 0x3C7 (odd)
        if (r_req_wr) begin
          if (r_req_bs[0]) w_pel_mask = r_req_data[7:0];
          if (r_req_bs[1]) begin
            w_rd_idx   = r_req_data[15:8];
            w_rd_phase = PH_R;
            w_rd_mode  = 1'b1;
          end
        end else begin
          if (r_req_bs[0]) w_rd_data[7:0]  = r_pel_mask;
          if (r_req_bs[1]) w_rd_data[15:8] = {6'b0, r_rd_mode ? 2'b11 : 2'b00};
        end
      end else begin
        // 0x3C8 (even) / 0x3C9 (odd)
        if (r_req_wr) begin
          if (r_req_bs[0]) begin
            w_wr_idx   = r_req_data[7:0];
            w_wr_phase = PH_R;
            w_rd_mode  = 1'b0;
          end
          if (r_req_bs[1]) begin
            case (w_wr_phase)
              PH_R: begin
                w_stage_r  = r_req_data[13:8];
                w_wr_phase = PH_G;
              end
              PH_G: begin
                w_stage_g  = r_req_data[13:8];
                w_wr_phase = PH_B;
              end
              default: begin
                w_ram_we    = 1'b1;
                w_ram_waddr = w_wr_idx;
                w_ram_wdata = {w_stage_r, w_stage_g, r_req_data[13:8]};
                w_wr_idx    = w_wr_idx + 8'd1;
                w_wr_phase  = PH_R;
              end
            endcase
          end
        end else begin
          if (r_req_bs[0]) w_rd_data[7:0] = r_wr_idx;
          if (r_req_bs[1]) begin
            case (r_rd_phase)
              PH_R: begin
                w_rd_data[15:8] = {2'b00, w_rd_entry[17:12]};
                w_rd_phase      = PH_G;
              end
              PH_G: begin
                w_rd_data[15:8] = {2'b00, w_rd_entry[11:6]};
                w_rd_phase      = PH_B;
              end
              default: begin
                w_rd_data[15:8] = {2'b00, w_rd_entry[5:0]};
                w_rd_idx        = r_rd_idx + 8'd1;
                w_rd_phase      = PH_R;
              end
            endcase
          end
        end
      end
    end
  end

  // Bus FSM: accept, apply side effects on BUSY->ACK, pulse ack for one cycle
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the values from before the edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_skip     <= 1'b0;
      r_req_addr <= 1'b0;
      r_req_wr   <= 1'b0;
      r_req_bs   <= 2'b00;
      r_req_data <= 16'h0000;
      r_ack      <= 1'b0;
      r_data_out <= 16'h0000;
      r_wr_idx   <= 8'h00;
      r_rd_idx   <= 8'h00;
      r_wr_phase <= PH_R;
      r_rd_phase <= PH_R;
      r_stage_r  <= 6'h00;
      r_stage_g  <= 6'h00;
      r_pel_mask <= 8'hFF;
      r_rd_mode  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_skip <= 1'b0;
          if (cs && data_m_access && !r_skip) begin
            r_req_addr <= data_m_addr;
            r_req_wr   <= data_m_wr_en;
            r_req_bs   <= data_m_bytesel;
            r_req_data <= data_m_data_in;
            r_state    <= S_BUSY;
          end
        end
        S_BUSY: begin
          r_wr_idx   <= w_wr_idx;
          r_rd_idx   <= w_rd_idx;
          r_wr_phase <= w_wr_phase;
          r_rd_phase <= w_rd_phase;
          r_stage_r  <= w_stage_r;
          r_stage_g  <= w_stage_g;
          r_pel_mask <= w_pel_mask;
          r_rd_mode  <= w_rd_mode;
          r_data_out <= w_rd_data;
          r_ack      <= 1'b1;
          r_state    <= S_ACK;
        end
        default: begin
          r_ack      <= 1'b0;
          r_data_out <= 16'h0000;
          r_skip     <= 1'b1;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

  // Palette write port; commit only happens from BUSY, which reset leaves at once
  // NOTE: the palette array has no reset; its contents survive reset by design.
  always_ff @(posedge clk) begin
    if (w_ram_we) ram[w_ram_waddr] <= w_ram_wdata;
  end

  // Pixel lookup: one index per cycle, sees the pre-commit value on a collision
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_pix <= 18'h0;
    else          r_pix <= ram[w_pix_addr];
  end

  assign data_m_ack      = r_ack;
  assign data_m_data_out = r_data_out;
  assign vga_dac_rd      = r_pix;

endmodule
